mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, slave-wait cycles before a transfer is aborted; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mN_valid  input  1  request from master N (N = 0, 1); held high until mN_ready.
REQ-005 mN_addr  input  32  master N byte address.
REQ-006 mN_wdata  input  32  master N write data.
REQ-007 mN_wstrb  input  4  master N byte strobes; 0 = read.
REQ-008 mN_ready  output  1  one-cycle completion pulse to master N.
REQ-009 mN_rdata  output  32  read data to master N; valid with mN_ready.
REQ-010 mN_err  output  1  qualifies mN_ready; 1 = transfer timed out.
REQ-011 s_valid  output  1  request to the shared memory.
REQ-012 s_addr, s_wdata, s_wstrb  output  32/32/4  captured request fields of the granted master.
REQ-013 s_ready  input  1  memory completion strobe.
REQ-014 s_rdata  input  32  memory read data; sampled when s_ready = 1.
REQ-015 owner  output  1  index of the granted master; meaningful only while busy = 1.
REQ-016 busy  output  1  1 in GRANT or DONE.

Function
REQ-017 Three-state FSM: IDLE, GRANT, DONE.
REQ-018 IDLE: with any mN_valid = 1, the arbiter selects a winner, registers its addr/wdata/wstrb into s_*, sets owner, and enters GRANT; s_valid = 1 on the next cycle (1-cycle request latency).
REQ-019 GRANT: s_valid = 1 and s_addr/s_wdata/s_wstrb remain stable until the transfer ends; a change in mN_* inputs has no effect.
REQ-020 GRANT with s_ready = 1 in a cycle: the arbiter registers s_rdata into m<owner>_rdata (zero for writes) and enters DONE; s_valid = 0 next cycle.
REQ-021 DONE lasts exactly one cycle: m<owner>_ready = 1, then IDLE; no arbitration occurs in DONE, so the completing master's still-high valid is never re-granted.
REQ-022 Minimum transfer time is 3 cycles plus slave wait; at most one outstanding transfer.
REQ-023 s_ready while not in GRANT is ignored.
REQ-024 Timeout: a 16-bit counter clears on entry to GRANT and increments each GRANT cycle with s_ready = 0; on reaching TIMEOUT_CYCLES (if nonzero) the FSM enters DONE with mN_rdata = 0, mN_err = 1, and s_valid = 0 next cycle.
REQ-025 s_ready = 1 in the same cycle the counter reaches TIMEOUT_CYCLES completes normally (err = 0).
REQ-026 mN_ready and mN_err are pulses; the non-owner's ready/err stay 0; mN_rdata holds until master N's next completion.
REQ-027 A master whose valid drops before being granted is simply not served.

Reset
REQ-028 reset = 1 at a clock edge forces IDLE, s_valid = 0, s_addr/s_wdata = 0, s_wstrb = 0, mN_ready = 0, mN_err = 0, mN_rdata = 0, owner = 0, busy = 0, counter = 0, last_owner = 1.
REQ-029 Reset during GRANT or DONE abandons the transfer; no ready pulse is issued for it.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both valids are high in IDLE, grant goes to the master not equal to last_owner (updated on each grant), so m0 wins first after reset and service then alternates.
REQ-031 Macro undefined: fixed priority; m0 always wins simultaneous requests; last_owner is unused.

Verification
REQ-032 m0 read addr 0x10, s_ready after 2 wait cycles with s_rdata 0x00500093 -> s_valid rises 1 cycle after m0_valid; m0_ready pulses once with m0_rdata = 0x00500093 and m0_err = 0; m1_ready stays 0.
REQ-033 m1 write addr 0x20, wdata 0xAABBCCDD, wstrb 4'b0011 -> s_addr = 0x20, s_wdata = 0xAABBCCDD, s_wstrb = 0011 while s_valid = 1; m1_ready pulses once.
REQ-034 m0 and m1 both request continuously for 4 transfers -> with MEM_ARB_ROUND_ROBIN_EN owner sequence is 0,1,0,1; without it 0,0,0,0.
REQ-035 TIMEOUT_CYCLES = 8, s_ready held 0 -> s_valid falls after 8 GRANT cycles; m0_ready = 1, m0_err = 1, m0_rdata = 0; the next request is served normally.
REQ-036 reset pulsed for 1 cycle while in GRANT -> s_valid = 0 and busy = 0 next cycle; no mN_ready pulse; a subsequent m1 request is granted.
REQ-037 s_ready pulsed in IDLE with no requests -> no state change and no ready pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-outstanding shared memory port, with slave timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed m0 priority.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      r_state, w_next;
    logic        r_owner, r_err;
    logic [15:0] r_cnt;
    logic [31:0] r_s_addr, r_s_wdata, r_m0_rdata, r_m1_rdata;
    logic [3:0]  r_s_wstrb;
    logic        w_win, w_timeout, w_any_req;
    logic [31:0] w_done_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        r_last_owner;
`endif

    assign w_any_req = m0_valid | m1_valid;

    always_comb begin
        w_win = m1_valid;
        if (m0_valid && m1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_win = ~r_last_owner;
`else
            w_win = 1'b0;
`endif
        end
    end

    // s_ready in the limit cycle wins over the timeout
    assign w_timeout    = (TO_LIMIT != 16'd0) && !s_ready && ((r_cnt + 16'd1) == TO_LIMIT);
    assign w_done_rdata = (s_ready && r_s_wstrb == 4'd0) ? s_rdata : 32'd0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = GRANT;
            GRANT:   if (s_ready || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 16'd0;
            r_s_addr   <= 32'd0;
            r_s_wdata  <= 32'd0;
            r_s_wstrb  <= 4'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_any_req) begin
                    r_owner   <= w_win;
                    r_err     <= 1'b0;
                    r_cnt     <= 16'd0;
                    r_s_addr  <= w_win ? m1_addr  : m0_addr;
                    r_s_wdata <= w_win ? m1_wdata : m0_wdata;
                    r_s_wstrb <= w_win ? m1_wstrb : m0_wstrb;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    r_last_owner <= w_win;
`endif
                end
                GRANT: begin
                    if (!s_ready) r_cnt <= r_cnt + 16'd1;
                    if (s_ready || w_timeout) begin
                        r_err <= !s_ready;
                        if (r_owner) r_m1_rdata <= w_done_rdata;
                        else         r_m0_rdata <= w_done_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_valid  = (r_state == GRANT);
    assign busy     = (r_state != IDLE);
    assign owner    = r_owner;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign m0_ready = (r_state == DONE) && !r_owner;
    assign m1_ready = (r_state == DONE) &&  r_owner;
    assign m0_err   = m0_ready && r_err;
    assign m1_err   = m1_ready && r_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: transaction-level model of grants, data and timeouts.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, owner, busy;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .owner(owner), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        req [2];
    bit          pend [2];
    logic [31:0] exp_rdata [2];
    int          last_own;
    int          n_chk = 0, n_fail = 0;
    int          exp_seq [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_masters();
        m0_valid = pend[0]; m0_addr = req[0].addr; m0_wdata = req[0].wdata; m0_wstrb = req[0].wstrb;
        m1_valid = pend[1]; m1_addr = req[1].addr; m1_wdata = req[1].wdata; m1_wstrb = req[1].wstrb;
    endtask

    task automatic new_req(input int n);
        req[n].addr  = $urandom;
        req[n].wdata = $urandom;
        req[n].wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        pend[n]      = 1'b1;
    endtask

    // Arbitration rule from the requirements, not from the RTL's encoding
    function automatic int pick();
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last_own == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return pend[0] ? 0 : 1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_svalid"}, s_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, {m1_ready, m0_ready}, 0);
        chk({tag, "_err"}, {m1_err, m0_err}, 0);
        chk({tag, "_rdata0"}, m0_rdata, exp_rdata[0]);
        chk({tag, "_rdata1"}, m1_rdata, exp_rdata[1]);
    endtask

    task automatic idle_cycle(input bit pulse);
        s_ready = pulse;
        s_rdata = $urandom;
        @(negedge clk);
        chk_quiet("idle");
        tick();
        s_ready = 1'b0;
    endtask

    // Entered in an IDLE cycle with at least one request driven; returns in the following IDLE cycle.
    task automatic run_xfer(input int w, input logic [31:0] rd, input bit keep, input bit churn,
                            output int win);
        req_t r;
        bit   tout;
        bit   done;
        int   oth;
        win  = pick();
        oth  = 1 - win;
        r    = req[win];
        tout = (w >= TO);
        done = 1'b0;
        last_own = win;
        @(negedge clk);
        chk_quiet("arb");
        tick();
        for (int k = 0; k < TO && !done; k++) begin
            if (!tout && k == w) begin
                s_ready = 1'b1;
                s_rdata = rd;
            end
            if (churn && $urandom_range(0, 3) == 0) begin
                if (pend[oth]) pend[oth] = 1'b0;
                else           new_req(oth);
                drive_masters();
            end
            @(negedge clk);
            chk("g_svalid", s_valid, 1);
            chk("g_addr", s_addr, r.addr);
            chk("g_wdata", s_wdata, r.wdata);
            chk("g_wstrb", {28'd0, s_wstrb}, {28'd0, r.wstrb});
            chk("g_owner", owner, 32'(win));
            chk("g_busy", busy, 1);
            chk("g_ready", {m1_ready, m0_ready}, 0);
            tick();
            if (!tout && k == w) done = 1'b1;
        end
        exp_rdata[win] = (tout || r.wstrb != 4'd0) ? 32'd0 : rd;
        s_ready = 1'($urandom_range(0, 1));
        s_rdata = $urandom;
        @(negedge clk);
        chk("d_svalid", s_valid, 0);
        chk("d_busy", busy, 1);
        chk("d_owner", owner, 32'(win));
        chk("d_ready_win", win ? m1_ready : m0_ready, 1);
        chk("d_ready_oth", win ? m0_ready : m1_ready, 0);
        chk("d_err_win", win ? m1_err : m0_err, 32'(tout));
        chk("d_err_oth", win ? m0_err : m1_err, 0);
        chk("d_rdata_win", win ? m1_rdata : m0_rdata, exp_rdata[win]);
        chk("d_rdata_oth", win ? m0_rdata : m1_rdata, exp_rdata[oth]);
        tick();
        s_ready   = 1'b0;
        pend[win] = 1'b0;
        if (keep) new_req(win);
        drive_masters();
    endtask

    initial begin
        int win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        reset = 1'b1; s_ready = 1'b0; s_rdata = 32'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        req[0] = '0; req[1] = '0;
        exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
        last_own = 1;
        drive_masters();
        tick(); tick();
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_owner", owner, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_swstrb", {28'd0, s_wstrb}, 0);
        tick();
        reset = 1'b0;

        // m0 read with two wait cycles
        new_req(0); req[0].addr = 32'h10; req[0].wstrb = 4'h0; drive_masters();
        run_xfer(2, 32'h00500093, 1'b0, 1'b0, win);
        chk("rd_m0_rdata", m0_rdata, 32'h00500093);

        // m1 partial write
        new_req(1); req[1].addr = 32'h20; req[1].wdata = 32'hAABBCCDD; req[1].wstrb = 4'b0011;
        drive_masters();
        run_xfer(1, $urandom, 1'b0, 1'b0, win);

        // stray s_ready while idle
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // timeout, then limit-cycle completion, then a normal transfer
        new_req(0); req[0].wstrb = 4'h0; drive_masters();
        run_xfer(20, $urandom, 1'b0, 1'b0, win);
        new_req(0); req[0].wstrb = 4'h0; drive_masters();
        run_xfer(TO - 1, 32'h12345678, 1'b0, 1'b0, win);
        chk("lim_rdata", m0_rdata, 32'h12345678);
        new_req(0); drive_masters();
        run_xfer(0, $urandom, 1'b0, 1'b0, win);

        // reset while a transfer is in GRANT
        new_req(0); drive_masters();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("prerst_svalid", s_valid, 1);
        reset = 1'b1; pend[0] = 1'b0; drive_masters();
        tick();
        reset = 1'b0;
        last_own = 1; exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
        @(negedge clk);
        chk_quiet("postrst");
        tick();
        new_req(1); drive_masters();
        run_xfer(1, $urandom, 1'b0, 1'b0, win);
        chk("postrst_win", 32'(win), 1);

        // both masters requesting back to back
        new_req(0); new_req(1); drive_masters();
        for (int i = 0; i < 4; i++) begin
            run_xfer($urandom_range(0, 3), $urandom, 1'b1, 1'b0, win);
            chk("seq_owner", 32'(win), 32'(exp_seq[i]));
        end

        for (int it = 0; it < 150; it++) begin
            if (!pend[0] && $urandom_range(0, 2) == 0) new_req(0);
            if (!pend[1] && $urandom_range(0, 2) == 0) new_req(1);
            drive_masters();
            if (pend[0] || pend[1])
                run_xfer($urandom_range(0, 11), $urandom, 1'($urandom_range(0, 1)), 1'b1, win);
            else
                idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
